pipe_reg_array: RTL and testbench
=================================

Name: pipe_reg_array

Overview:
- Parametrised successor to the team's single-bit clearable flip-flop.
- A WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, valid/ready backpressure, bubble collapsing and synchronous flush.
- Sits between MAC datapath stages (multiplier output → accumulator input) so stage latency can be tuned without rewriting control.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1)

Ports:
- clk  input  1  rising-edge clock, only clock
- clr  input  1  synchronous active-low reset (clr=0 at posedge clears)
- in_data  input  WIDTH  upstream data
- in_vld  input  1  upstream data valid
- in_rdy  output  1  pipeline can accept in_data this cycle
- out_data  output  WIDTH  last-stage data
- out_vld  output  1  last stage holds valid data
- out_rdy  input  1  downstream accepts out_data this cycle
- flush  input  1  discard all in-flight data

Behaviour:
- Reset: clr=0 at posedge clears all stage data to 0 and all stage valid bits to 0; out_data=0, out_vld=0. clr overrides flush and all handshakes. in_rdy is combinational and reads 1 once valids are 0.
- Stage k (0..DEPTH-1) holds data[k] and vld[k]. Stage 0 is input-side; stage DEPTH-1 drives out_data/out_vld directly (registered outputs).
- Advance:
  - adv[DEPTH-1] = !vld[DEPTH-1] | out_rdy
  - adv[k] = !vld[k] | adv[k+1] for k<DEPTH-1 (bubble collapse: an empty stage always loads)
- in_rdy = adv[0] & !flush. This is combinational from out_rdy through the valid chain; no registered ready.
- Transfers:
  - Input transfer when in_vld & in_rdy.
  - Output transfer when out_vld & out_rdy.
- On posedge with adv[k]:
  - Stage k loads from stage k-1 (stage 0 loads from in_data and in_vld & in_rdy).
  - Data of a stage loading an invalid beat is don't-care, but the implementation holds the previous data (no toggle) when the source is invalid.
- Stage without adv holds data and valid unchanged (stall). out_data is stable while out_vld=1 and out_rdy=0.
- Latency: a beat accepted at edge N into an empty pipe appears with out_vld=1 after edge N+DEPTH-1, i.e. DEPTH cycles from the in_vld cycle.
- Throughput: one beat per cycle when out_rdy stays 1.
- Capacity: DEPTH beats. When full and out_rdy=0, in_rdy=0. Full with out_rdy=1 gives in_rdy=1 (simultaneous pop and push).
- Flush: flush=1 at posedge clears all vld to 0 and leaves data unchanged. in_rdy=0 during the flush cycle, so no beat is accepted. A beat presented at the last stage with out_rdy=1 in the flush cycle is treated as transferred by downstream (out_vld was 1). Next cycle the pipe is empty.
- Reset mid-operation: all in-flight beats are lost, with no partial output.
- Ordering: strict FIFO; no beat duplicated or dropped except by flush or clr.

Optional Feature:
- Macro PIPE_REG_ARRAY_OCC_EN.
- Defined: adds output occ [$clog2(DEPTH+1)-1:0], a registered count of valid stages.
  - occ is updated each edge: +1 on input transfer, -1 on output transfer, unchanged on both or neither.
  - Forced to 0 on clr=0 or flush=1.
  - Must always equal popcount(vld).
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package mac_pkg holds:
  - default WIDTH/DEPTH constants for MAC stages
  - the occupancy-width function (clog2(DEPTH+1)) so the bench sizes occ identically
- One sub-module is natural: pipe_stage (one WIDTH-bit data register plus valid bit, with load/hold/clear inputs), instantiated DEPTH times by generate.
- The advance chain stays in the parent.

Test Plan:
- Reset: drive clr=0 for 2 cycles with in_vld=1, in_data=8'hAA → out_vld=0, out_data=8'h00, in_rdy=1 after release, occ=0.
- Latency/streaming (WIDTH=8, DEPTH=3, out_rdy=1): push 8'h01..8'h05 back-to-back → out_vld first high 3 cycles after first push; outputs 01..05 in order on consecutive cycles; in_rdy stays 1.
- Backpressure/full: out_rdy=0, push 8'h10,8'h11,8'h12,8'h13 → first three accepted; in_rdy=0 on the 4th cycle; out_data holds 8'h10. Raise out_rdy → 10,11,12,13 delivered with no loss; occ goes 3→3 (push and pop together)→…→0.
- Bubble collapse: DEPTH=3, push 8'h20, idle 1 cycle, push 8'h21, out_rdy=0 → both beats stack in stages 2 and 1; in_rdy=1 with occ=2.
- Flush: with occ=3, assert flush=1 for one cycle with in_vld=1, in_data=8'h55 → in_rdy=0 that cycle; next cycle out_vld=0 and occ=0; 8'h55 never emerges.
- Mid-operation reset: 2 beats in flight, pulse clr=0 one cycle → out_vld=0 next cycle; the in-flight beats never appear.

Source files
------------

// File: rtl/pipe_reg_array_pkg.sv
// Shared MAC pipeline definitions: default stage geometry and the
// occupancy-counter width helper. Used by pipe_reg_array, pipe_stage and
// by any bench that must size the occupancy port identically.
package mac_pkg;

    // Default data width of one MAC datapath stage (multiplier output).
    localparam int MAC_WIDTH = 8;

    // Default number of register stages between multiplier and accumulator.
    localparam int MAC_DEPTH = 3;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : mac_pkg

// File: rtl/pipe_reg_array_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Load copies the upstream valid bit; the data register only changes when
// the upstream beat is valid, so bubbles passing through cause no toggling.
// Flush drops the valid bit but keeps the data register untouched.
module pipe_stage
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_vld,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    // Stage register: clear beats flush, flush beats load, otherwise stall.
    always_ff @(posedge clk) begin
        if (!clr) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (flush) begin
            vld  <= 1'b0;
        end else if (load) begin
            vld <= src_vld;
            if (src_vld) begin
                data <= src_data;
            end
        end
    end

endmodule : pipe_stage

// File: rtl/pipe_reg_array.sv
// pipe_reg_array: WIDTH-bit, DEPTH-stage register pipeline with per-stage
// valid bits, valid/ready backpressure, bubble collapsing and flush.
// Optional feature macro: PIPE_REG_ARRAY_OCC_EN adds the registered
// occupancy output occ (number of valid stages).
// The last stage drives out_data/out_vld directly, so outputs are registered;
// in_rdy is combinational from out_rdy through the valid chain.
module pipe_reg_array
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int DEPTH = MAC_DEPTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy,
    input  logic             flush
`ifdef PIPE_REG_ARRAY_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [WIDTH-1:0] src_data   [DEPTH];
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] adv;

    // Advance chain: stage k may load when it or any stage downstream of it
    // is empty, or when the consumer is taking the last stage. Written in
    // closed form over the valid bits so there is no combinational
    // self-dependency between adv bits.
    always_comb begin
        adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic room;
            room = out_rdy;
            for (int j = k; j < DEPTH; j++) begin
                room = room | ~stage_vld[j];
            end
            adv[k] = room;
        end
    end

    // No beat is accepted during a flush cycle.
    assign in_rdy = adv[0] & ~flush;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign src_data[k] = in_data;
                assign src_vld[k]  = in_vld & in_rdy;
            end else begin : g_body
                assign src_data[k] = stage_data[k-1];
                assign src_vld[k]  = stage_vld[k-1];
            end

            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .clr      (clr),
                .flush    (flush),
                .load     (adv[k]),
                .src_data (src_data[k]),
                .src_vld  (src_vld[k]),
                .data     (stage_data[k]),
                .vld      (stage_vld[k])
            );
        end
    endgenerate

    assign out_data = stage_data[DEPTH-1];
    assign out_vld  = stage_vld[DEPTH-1];

`ifdef PIPE_REG_ARRAY_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = out_vld & out_rdy;

    // Occupancy counter tracking the number of valid stages.
    always_ff @(posedge clk) begin
        if (!clr) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
`endif

endmodule : pipe_reg_array

// File: tb/tb_pipe_reg_array.sv
// Self-checking bench for pipe_reg_array (WIDTH=8, DEPTH=3): a directed
// vector table for the reset/stream/backpressure/bubble/flush/reset cases,
// then randomized traffic against a queue-of-beats reference model.
module tb_pipe_reg_array;
    import mac_pkg::*;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int OW = occ_width(D);

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] in_data;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] out_data;
    logic         out_vld;
    logic         out_rdy;
    logic         flush;
`ifdef PIPE_REG_ARRAY_OCC_EN
    logic [OW-1:0] occ;
`endif

    int errors = 0;
    int checks = 0;

    pipe_reg_array #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .clr      (clr),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .flush    (flush)
`ifdef PIPE_REG_ARRAY_OCC_EN
        ,
        .occ      (occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic         vld;
        logic [W-1:0] data;
        logic         ordy;
        logic         flush;
        logic         chk_irdy;
        logic         e_irdy;
        logic         e_ovld;
        logic [W-1:0] e_odata;
        int           e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic v, logic [W-1:0] d, logic r, logic f,
                                logic ck, logic ei, logic eo, logic [W-1:0] ed, int eoc);
        vec_t t;
        t.clr = c; t.vld = v; t.data = d; t.ordy = r; t.flush = f;
        t.chk_irdy = ck; t.e_irdy = ei; t.e_ovld = eo; t.e_odata = ed; t.e_occ = eoc;
        return t;
    endfunction

    // Reference model: in-flight beats in FIFO order with their stage index.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } beat_t;

    beat_t        mq[$];
    logic [W-1:0] m_last;

    function automatic logic m_in_rdy();
        return ((mq.size() < D) || out_rdy) && !flush;
    endfunction

    function automatic logic m_out_vld();
        return (mq.size() > 0) && (mq[0].pos == D - 1);
    endfunction

    task automatic m_edge();
        logic push;
        int   lim;
        int   np;
        push = in_vld && m_in_rdy();
        if (!clr) begin
            mq.delete();
            m_last = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (m_out_vld() && out_rdy) void'(mq.pop_front());
            lim = D - 1;
            for (int i = 0; i < mq.size(); i++) begin
                np = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
                mq[i].pos = np;
                lim = np - 1;
                if (np == D - 1) m_last = mq[i].d;
            end
            if (push) begin
                mq.push_back('{d: in_data, pos: 0});
                if (D == 1) m_last = in_data;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic c, logic v, logic [W-1:0] d, logic r, logic f);
        clr = c; in_vld = v; in_data = d; out_rdy = r; flush = f;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset with live input, then release.
        tbl.push_back(mk(1'b0,1'b1,8'hAA,1'b1,1'b0, 1'b0,1'b0, 1'b0,8'h00,0));
        tbl.push_back(mk(1'b0,1'b1,8'hAA,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,0));
        // Streaming 01..05 with out_rdy=1.
        tbl.push_back(mk(1'b1,1'b1,8'h01,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,1));
        tbl.push_back(mk(1'b1,1'b1,8'h02,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,2));
        tbl.push_back(mk(1'b1,1'b1,8'h03,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h01,3));
        tbl.push_back(mk(1'b1,1'b1,8'h04,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h02,3));
        tbl.push_back(mk(1'b1,1'b1,8'h05,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h03,3));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h04,2));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h05,1));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h05,0));
        // Backpressure until full, then drain.
        tbl.push_back(mk(1'b1,1'b1,8'h10,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h05,1));
        tbl.push_back(mk(1'b1,1'b1,8'h11,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h05,2));
        tbl.push_back(mk(1'b1,1'b1,8'h12,1'b0,1'b0, 1'b1,1'b1, 1'b1,8'h10,3));
        tbl.push_back(mk(1'b1,1'b1,8'h13,1'b0,1'b0, 1'b1,1'b0, 1'b1,8'h10,3));
        tbl.push_back(mk(1'b1,1'b1,8'h13,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h11,3));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h12,2));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b1,8'h13,1));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h13,0));
        // Bubble collapse under out_rdy=0.
        tbl.push_back(mk(1'b1,1'b1,8'h20,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h13,1));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h13,1));
        tbl.push_back(mk(1'b1,1'b1,8'h21,1'b0,1'b0, 1'b1,1'b1, 1'b1,8'h20,2));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1, 1'b1,8'h20,2));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1, 1'b1,8'h20,2));
        // Fill to 3, then flush with a beat offered.
        tbl.push_back(mk(1'b1,1'b1,8'h22,1'b0,1'b0, 1'b1,1'b1, 1'b1,8'h20,3));
        tbl.push_back(mk(1'b1,1'b1,8'h55,1'b0,1'b1, 1'b1,1'b0, 1'b0,8'h20,0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h20,0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h20,0));
        // Two beats in flight, then a one-cycle reset.
        tbl.push_back(mk(1'b1,1'b1,8'h30,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h20,1));
        tbl.push_back(mk(1'b1,1'b1,8'h31,1'b0,1'b0, 1'b1,1'b1, 1'b0,8'h20,2));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1, 1'b0,8'h00,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clr, tbl[i].vld, tbl[i].data, tbl[i].ordy, tbl[i].flush);
            #1;
            if (tbl[i].chk_irdy) chk($sformatf("vec%0d in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_irdy));
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("vec%0d out_vld", i), 32'(out_vld), 32'(tbl[i].e_ovld));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].e_odata));
`ifdef PIPE_REG_ARRAY_OCC_EN
            chk($sformatf("vec%0d occ", i), 32'(occ), 32'(tbl[i].e_occ));
`endif
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            #1;
            chk($sformatf("rnd%0d in_rdy", n), 32'(in_rdy), 32'(m_in_rdy()));
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("rnd%0d out_vld", n), 32'(out_vld), 32'(m_out_vld()));
            chk($sformatf("rnd%0d out_data", n), 32'(out_data), 32'(m_last));
`ifdef PIPE_REG_ARRAY_OCC_EN
            chk($sformatf("rnd%0d occ", n), 32'(occ), 32'(mq.size()));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_reg_array
